// File: rtl/cnt_seq_checker.sv
// Sequence monitor for a free-running counter: checks +1 steps, counts wraps and errors,
// and latches a FAULT state after ERR_LIMIT consecutive mismatches.
module cnt_seq_checker #(
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned WRAP_W     = 8,
    parameter int unsigned ERR_W      = 8,
    parameter int unsigned ERR_LIMIT  = 3,
    parameter bit          ALLOW_HOLD = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cnt_vld,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              clr,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              step_err,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  exp_cnt,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StTrack = 2'd1,
        StFault = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  prev_q, prev_d;
    logic [3:0]        consec_q, consec_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_sticky_q, err_sticky_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic              step_err_q, step_err_d;
    logic [CNT_W-1:0]  exp_cnt_q, exp_cnt_d;
    logic [CNT_W-1:0]  prev_inc;

    assign prev_inc = prev_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        consec_d     = consec_q;
        wrap_cnt_d   = wrap_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        exp_cnt_d    = exp_cnt_q;
        wrap_pulse_d = 1'b0;
        step_err_d   = 1'b0;

        if (clr) begin
            state_d      = StIdle;
            prev_d       = '0;
            consec_d     = '0;
            wrap_cnt_d   = '0;
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
            exp_cnt_d    = '0;
        end else if (cnt_vld) begin
            unique case (state_q)
                StIdle: begin
                    prev_d   = cnt;
                    consec_d = '0;
                    state_d  = StTrack;
                end
                StTrack, StFault: begin
                    if (cnt == prev_inc) begin
                        prev_d   = cnt;
                        consec_d = '0;
                        // Wrap accounting is suspended once faulted
                        if (state_q == StTrack && prev_q == {CNT_W{1'b1}}) begin
                            wrap_pulse_d = 1'b1;
                            if (wrap_cnt_q != {WRAP_W{1'b1}}) begin
                                wrap_cnt_d = wrap_cnt_q + 1'b1;
                            end
                        end
                    end else if (ALLOW_HOLD && cnt == prev_q) begin
                        consec_d = '0;
                    end else begin
                        step_err_d   = 1'b1;
                        err_sticky_d = 1'b1;
                        prev_d       = cnt;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (consec_q != 4'hF) begin
                            consec_d = consec_q + 4'd1;
                        end
                        if (state_q == StTrack && (32'(consec_q) + 32'd1) >= ERR_LIMIT) begin
                            state_d = StFault;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
            exp_cnt_d = (state_d == StIdle) ? '0 : prev_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            prev_q       <= '0;
            consec_q     <= '0;
            wrap_cnt_q   <= '0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
            wrap_pulse_q <= 1'b0;
            step_err_q   <= 1'b0;
            exp_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            consec_q     <= consec_d;
            wrap_cnt_q   <= wrap_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
            wrap_pulse_q <= wrap_pulse_d;
            step_err_q   <= step_err_d;
            exp_cnt_q    <= exp_cnt_d;
        end
    end

    assign wrap_pulse = wrap_pulse_q;
    assign wrap_cnt   = wrap_cnt_q;
    assign step_err   = step_err_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign exp_cnt    = exp_cnt_q;
    assign state      = state_q;

endmodule

// File: doc/cnt_seq_checker.md
# cnt_seq_checker

Downstream monitor for the free-running 4-bit counter. It samples the counter output every valid cycle, checks that each value is the previous value plus one (mod 2^CNT_W), counts wrap-arounds, and counts and flags sequence errors. A small state machine declares a fault after repeated consecutive errors. Sits directly on the counter's `cnt` output, in the bench and in silicon, as a self-check and statistics stage.

## Interface
- CNT_W, 4, width of the monitored count
- WRAP_W, 8, width of the saturating wrap counter
- ERR_W, 8, width of the saturating error counter
- ERR_LIMIT, 3, consecutive mismatches that force FAULT (1..15)
- ALLOW_HOLD, 1, 1 = a sample equal to the previous one is a legal stall
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cnt_vld  in  1  `cnt` is valid this cycle (tie 1 for a free-running counter)
- cnt  in  CNT_W  counter value under test
- clr  in  1  synchronous clear of statistics, sticky flag and state
- wrap_pulse  out  1  one-cycle pulse: accepted step from 2^CNT_W-1 to 0
- wrap_cnt  out  WRAP_W  wraps seen, saturating
- step_err  out  1  one-cycle pulse: mismatching sample
- err_sticky  out  1  set by any step_err, cleared only by clr/reset
- err_cnt  out  ERR_W  mismatches seen, saturating
- exp_cnt  out  CNT_W  expected next value (prev+1 mod 2^CNT_W); 0 in IDLE
- state  out  2  0 IDLE, 1 TRACK, 2 FAULT

## Operation
- Reset (async, active-high): state IDLE, all outputs and internal regs (prev, consec) = 0, immediately on assertion, independent of clk.
- Priority per edge: reset > clr > sample processing. clr with cnt_vld=1: sample discarded, state→IDLE, wrap_cnt/err_cnt/err_sticky/consec/exp_cnt = 0, pulses 0.
- cnt_vld=0: no state or statistics change; pulses 0.
- IDLE: first valid sample loads prev; →TRACK. No check, no wrap.
- TRACK, valid sample s:
  - s == prev+1 mod 2^CNT_W: match. prev←s, consec←0. If prev was 2^CNT_W-1 (s==0): wrap_pulse=1, wrap_cnt++ (saturating).
  - s == prev and ALLOW_HOLD=1: stall. No error, no wrap, consec←0.
  - otherwise (including s==prev with ALLOW_HOLD=0): mismatch. step_err=1, err_sticky←1, err_cnt++ (saturating), prev←s (resync), consec++. If consec reaches ERR_LIMIT: →FAULT.
- FAULT: checking continues (err_cnt, step_err, prev updated as in TRACK); wrap detection suspended (no wrap_pulse, wrap_cnt frozen). Exit only via clr (→IDLE) or reset.
- Arithmetic: expected value computed in CNT_W bits, natural wrap. Counters saturate at all-ones, never roll over.

## Timing
- All outputs registered. Sample present before edge N → wrap_pulse/step_err/counters/state/exp_cnt updated at edge N, visible during cycle N+1 (one-cycle latency).
- Pulses last exactly one cycle per event; back-to-back events give back-to-back pulses.
- FAULT entry occurs at the same edge as the ERR_LIMIT-th consecutive step_err.
- Reset deassertion: first edge with reset low is a normal IDLE cycle.

## Test plan
- Reset, then cnt_vld=1 with cnt 0,1,…,15,0,…,15,0 (33 samples) → two wrap_pulses, wrap_cnt=2, err_cnt=0, err_sticky=0, state TRACK, exp_cnt=1.
- Counter held in reset: cnt 0,0,0,1,2 (ALLOW_HOLD=1) → no step_err, exp_cnt=3; same with ALLOW_HOLD=0 → err_cnt=2, err_sticky=1, state TRACK.
- Single skip 3,4,6,7 → one step_err pulse the cycle after 6 is sampled, err_cnt=1, err_sticky=1, state TRACK, exp_cnt=8.
- Three consecutive mismatches 5,9,2,12 (ERR_LIMIT=3) → err_cnt=3, state FAULT; further 13,14,15,0 → no wrap_pulse; clr with cnt_vld=1 → state IDLE, all counters 0, err_sticky 0.
- WRAP_W=2, 5 full count cycles → wrap_cnt saturates at 3, 5 wrap_pulses still emitted.
- Assert reset between edges mid-stream (wrap_cnt=4, state TRACK) → all outputs 0 and state IDLE before next clk edge; after release, first sample handled as IDLE.
